// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: register-file geometry, default load latency,
// and the register-address type used across the ID-stage hazard logic.
package riscv_pipe_pkg;

    localparam int REG_AW       = 5;
    localparam int NUM_REGS     = 32;
    localparam int LOAD_LAT_DEF = 1;
    localparam int CNT_W        = 3;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : riscv_pipe_pkg

// File: rtl/hazard_cnt.sv
// One scoreboard countdown counter: load to a value, clear, or count down to
// zero, in that priority; o_busy flags a result that is not yet forwardable.
module hazard_cnt
    import riscv_pipe_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_set,
    input  logic [CW-1:0] i_set_val,
    input  logic          i_clr,
    output logic          o_busy
);

    logic [CW-1:0] r_cnt;

    // NOTE: non-blocking assignment so every counter updates from pre-edge state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_set) begin
            r_cnt <= i_set_val;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule : hazard_cnt

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard for the ID stage: one countdown per register.
// Optional stall_count performance counter is enabled by HAZARD_PERF_EN.
module hazard_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int NREGS    = NUM_REGS,
    parameter int AW       = REG_AW,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int CW       = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_id,
    input  logic [AW-1:0] rs1Addr_id,
    input  logic [AW-1:0] rs2Addr_id,
    input  logic          rs1Used_id,
    input  logic          rs2Used_id,
    input  logic [AW-1:0] rdAddr_id,
    input  logic          RegWrite_id,
    input  logic          MemRead_id,
    input  logic          Flush,
    output logic          Stall,
    output logic          IFWrite,
`ifdef HAZARD_PERF_EN
    output logic [31:0]   stall_count,
`endif
    output logic          pending_any
);

    localparam int NSLOTS = 1 << AW;

    logic [NSLOTS-1:0] w_busy;
    logic              w_rs1_pend;
    logic              w_rs2_pend;
    logic              w_issue;
    logic              w_wr_en;

    // Slots for x0 and for addresses >= NREGS are tied idle, so they never
    // stall and never match a destination.
    assign w_rs1_pend = rs1Used_id & w_busy[rs1Addr_id];
    assign w_rs2_pend = rs2Used_id & w_busy[rs2Addr_id];

    assign Stall       = valid_id & ~Flush & (w_rs1_pend | w_rs2_pend);
    assign IFWrite     = ~Stall;
    assign w_issue     = valid_id & ~Stall & ~Flush;
    assign w_wr_en     = w_issue & RegWrite_id;
    assign pending_any = |w_busy;

    for (genvar r = 0; r < NSLOTS; r++) begin : g_reg
        if (r == 0 || r >= NREGS) begin : g_none
            assign w_busy[r] = 1'b0;
        end else begin : g_cnt
            logic w_hit;
            assign w_hit = w_wr_en & (rdAddr_id == AW'(r));

            hazard_cnt #(
                .CW(CW)
            ) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .i_set    (w_hit & MemRead_id),
                .i_set_val(CW'(LOAD_LAT)),
                .i_clr    (w_hit & ~MemRead_id),
                .o_busy   (w_busy[r])
            );
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (Stall && r_stall_count != 32'hFFFF_FFFF) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule : hazard_scoreboard
